// File: rtl/uart_rx_fifo.sv
// UART receive channel: oversampled deserialiser with runtime frame format,
// feeding a first-word-fall-through RX FIFO with RTS flow control and sticky errors.
module uart_rx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              en_i,
    input  logic                              rx_i,
    input  logic [DIV_W-1:0]                  baud_div_i,
    input  logic [3:0]                        cfg_bits_i,
    input  logic [1:0]                        cfg_parity_i,
    input  logic                              cfg_stop2_i,
    input  logic                              rpop_i,
    input  logic                              err_clr_i,
    output logic [DATA_W-1:0]                 rdata_o,
    output logic                              rvalid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              rts_o,
    output logic                              parity_err_o,
    output logic                              frame_err_o,
    output logic                              overrun_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE/2 - 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] RTS_TH  = CW'(FIFO_DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic                rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [OW-1:0]       os_cnt_q, os_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_acc_q, par_acc_d;
    logic                par_bad_q, par_bad_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic [3:0]          bits_q, bits_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                stop2_q, stop2_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   push_data_q;
    logic                push_perr_q;
    logic                ferr_set;
    logic                fall, tick, sample;

    logic [AW:0]         wptr_q, rptr_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                full, empty, do_pop, do_push, ovr_set;
    logic                rts_q, perr_q, ferr_q, ovr_q;

    assign fall   = rx_prev_q & ~rx_s2_q;
    assign tick   = (state_q != IDLE) && (tick_cnt_q == '0);
    assign sample = tick && (os_cnt_q == ((state_q == START) ? OS_MID : OS_LAST));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_bad_d  = par_bad_q;
        stop_cnt_d = stop_cnt_q;
        bits_d     = bits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        push_d     = 1'b0;
        ferr_set   = 1'b0;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? baud_div_i : tick_cnt_q - 1'b1;
            if (tick) os_cnt_d = sample ? '0 : os_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (en_i && fall) begin
                    state_d    = START;
                    tick_cnt_d = baud_div_i;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_acc_d  = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_cnt_d = 1'b0;
                    bits_d     = (cfg_bits_i < 4'd5 || cfg_bits_i > 4'(DATA_W))
                                 ? 4'(DATA_W) : cfg_bits_i;
                    par_en_d   = ^cfg_parity_i;
                    par_odd_d  = (cfg_parity_i == 2'b01);
                    stop2_d    = cfg_stop2_i;
                end
            end
            START: if (sample) state_d = rx_s2_q ? IDLE : DATA;
            DATA: begin
                if (sample) begin
                    shift_d   = shift_q | (DATA_W'(rx_s2_q) << bit_cnt_q);
                    par_acc_d = par_acc_q ^ rx_s2_q;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == bits_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    par_bad_d = rx_s2_q != (par_acc_q ^ par_odd_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (!rx_s2_q) begin
                        ferr_set = 1'b1;
                        state_d  = IDLE;
                    end else if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling mid-frame drops everything in flight, including a frame
        // that would have completed this very cycle.
        if (!en_i) begin
            state_d  = IDLE;
            push_d   = 1'b0;
            ferr_set = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            tick_cnt_q  <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_bad_q   <= 1'b0;
            stop_cnt_q  <= 1'b0;
            bits_q      <= 4'(DATA_W);
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_perr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= rx_i;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            tick_cnt_q  <= tick_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_bad_q   <= par_bad_d;
            stop_cnt_q  <= stop_cnt_d;
            bits_q      <= bits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            push_q      <= push_d;
            if (push_d) begin
                push_data_q <= shift_q;
                push_perr_q <= par_bad_q;
            end
        end
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = rpop_i && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign do_push = push_q && (!full || do_pop);
    assign ovr_set = push_q && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            rts_q  <= 1'b1;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            rts_q  <= !(count_o >= RTS_TH);
            perr_q <= (perr_q & ~err_clr_i) | (push_q & push_perr_q);
            ferr_q <= (ferr_q & ~err_clr_i) | ferr_set;
            ovr_q  <= (ovr_q  & ~err_clr_i) | ovr_set;
        end
    end

    assign count_o      = CW'(wptr_q - rptr_q);
    assign rvalid_o     = !empty;
    assign rdata_o      = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign rts_o        = rts_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected words queued at send time and
// compared by a monitor whenever a word is popped; flags/count checked inline.
module tb_uart_rx_fifo;
    localparam int BITC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic [15:0] baud_div = '0;
    logic [3:0] cfg_bits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       rpop = 1'b0;
    logic       err_clr = 1'b0;
    logic [8:0] rdata;
    logic       rvalid;
    logic [4:0] count;
    logic       rts, parity_err, frame_err, overrun;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    uart_rx_fifo dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .rx_i(rx), .baud_div_i(baud_div),
        .cfg_bits_i(cfg_bits), .cfg_parity_i(cfg_parity), .cfg_stop2_i(cfg_stop2),
        .rpop_i(rpop), .err_clr_i(err_clr), .rdata_o(rdata), .rvalid_o(rvalid),
        .count_o(count), .rts_o(rts), .parity_err_o(parity_err),
        .frame_err_o(frame_err), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!reset && rpop && rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, scoreboard empty", rdata);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", rdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            rx = pat[i];
            step(BITC);
        end
        rx = 1'b1;
        step(BITC*2);
    endtask

    task automatic send8(input logic [7:0] d);
        send_raw({6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic pop();
        rpop = 1'b1;
        step(1);
        rpop = 1'b0;
        step(1);
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
    endtask

    initial begin
        step(3);
        check("reset_count", count, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_rts", rts, 1);
        check("reset_flags", {parity_err, frame_err, overrun}, 0);
        check("reset_rdata", rdata, 0);
        reset = 1'b0;
        step(5);

        // 8N1 0xA5
        exp_q.push_back(9'h0A5);
        send8(8'hA5);
        check("a5_rvalid", rvalid, 1);
        check("a5_rdata", rdata, 9'h0A5);
        check("a5_count", count, 1);
        check("a5_flags", {parity_err, frame_err, overrun}, 0);
        pop();
        check("a5_pop_rvalid", rvalid, 0);
        check("a5_pop_count", count, 0);

        // 7E1, 0x55 has four ones so a parity bit of 1 is wrong
        cfg_bits = 4'd7; cfg_parity = 2'b10;
        exp_q.push_back(9'h055);
        send_raw({6'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
        check("par_count", count, 1);
        check("par_err_set", parity_err, 1);
        pop();
        clr_err();
        check("par_err_clr", parity_err, 0);

        // 8N2 with bad second stop bit, then a good frame
        cfg_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        send_raw({5'b0, 1'b0, 1'b1, 8'h77, 1'b0}, 11);
        check("ferr_count", count, 0);
        check("ferr_set", frame_err, 1);
        exp_q.push_back(9'h03C);
        send_raw({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        check("n2_count", count, 1);
        check("n2_rdata", rdata, 9'h03C);
        pop();
        cfg_stop2 = 1'b0;
        clr_err();
        check("ferr_clr", frame_err, 0);

        // Fill: 17 frames, no pops
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(9'(8'h10 + i));
            if (i == 11) begin
                fork
                    send8(8'(8'h10 + i));
                    begin
                        for (int c = 0; c < 400 && count != 12; c++) @(negedge clk);
                        check("rts_wait_count", count, 12);
                        check("rts_lag_high", rts, 1);
                        @(negedge clk);
                        check("rts_low", rts, 0);
                    end
                join
            end else begin
                send8(8'(8'h10 + i));
            end
        end
        check("full_count", count, 16);
        check("full_overrun", overrun, 1);
        check("full_rdata", rdata, 9'h010);
        check("full_rts", rts, 0);
        clr_err();
        check("ovr_clr", overrun, 0);

        // 18th frame pushes in the same cycle as a pop
        exp_q.push_back(9'h040);
        fork
            send8(8'h40);
            begin
                repeat (155) @(posedge clk);
                #1 rpop = 1'b1;
                @(posedge clk);
                #1 rpop = 1'b0;
            end
        join
        check("pp_count", count, 16);
        check("pp_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) pop();
        check("drain_count", count, 0);
        check("drain_rts", rts, 1);

        // Short glitch in IDLE
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        check("glitch_count", count, 0);
        check("glitch_flags", {parity_err, frame_err, overrun}, 0);

        // Reset during DATA of 0xFF with a word already queued
        send8(8'h99);
        check("pre_reset_count", count, 1);
        fork
            send8(8'hFF);
            begin
                step(60);
                reset = 1'b1;
                exp_q.delete();
                step(2);
                check("rst_count", count, 0);
                check("rst_rvalid", rvalid, 0);
                check("rst_rts", rts, 1);
                reset = 1'b0;
            end
        join
        check("post_rst_count", count, 0);
        check("post_rst_flags", {parity_err, frame_err, overrun}, 0);
        exp_q.push_back(9'h081);
        send8(8'h81);
        check("x81_rdata", rdata, 9'h081);
        pop();

        // cfg_bits changes mid-frame; new length applies next frame
        exp_q.push_back(9'h0C3);
        fork
            send8(8'hC3);
            begin
                step(50);
                cfg_bits = 4'd5;
            end
        join
        exp_q.push_back(9'h01F);
        send_raw({9'b0, 1'b1, 5'h1F, 1'b0}, 7);
        check("cfg_count", count, 2);
        pop();
        pop();

        check("scoreboard_empty", exp_q.size(), 0);
        check("final_flags", {parity_err, frame_err, overrun}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
